// File: rtl/core_mac_seq.sv
// core_mac_seq: job sequencer for one core_mac instance.
// Accepts a chunk-count job and streams operand chunks straight into core_mac.
// It counts partial-sum returns, never MAC latency, and folds them into a wide
// accumulator. One result is presented per job on a valid/ready handshake.
module core_mac_seq #(
  parameter int MAC_NUM       = 8,
  parameter int IDATA_BIT     = 8,
  parameter int MAC_ODATA_BIT = 19,
  parameter int ACC_BIT       = 32,
  parameter int CNT_BIT       = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [CNT_BIT-1:0]           cfg_chunk_num,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IDATA_BIT*MAC_NUM-1:0] in_dataA,
  input  logic [IDATA_BIT*MAC_NUM-1:0] in_dataB,
  output logic [IDATA_BIT*MAC_NUM-1:0] mac_idataA,
  output logic [IDATA_BIT*MAC_NUM-1:0] mac_idataB,
  output logic                         mac_idata_valid,
  input  logic [MAC_ODATA_BIT-1:0]     mac_odata,
  input  logic                         mac_odata_valid,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_BIT-1:0]           out_data,
  output logic                         busy,
  output logic                         err_spurious
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic signed [ACC_BIT-1:0]  acc_q, acc_d;
  logic signed [ACC_BIT-1:0]  out_data_q, out_data_d;
  logic [CNT_BIT-1:0]         issue_cnt_q, issue_cnt_d;
  logic [CNT_BIT-1:0]         ret_cnt_q, ret_cnt_d;
  logic [CNT_BIT-1:0]         chunk_num_q, chunk_num_d;
  logic                       err_spurious_q, err_spurious_d;

  logic cfg_fire;
  logic in_fire;
  logic out_fire;
  logic ret_live;
  logic ret_stray;

  // Sign-extend a core_mac partial sum to accumulator width (works when widths are equal).
  function automatic logic signed [ACC_BIT-1:0] sext_ret(input logic [MAC_ODATA_BIT-1:0] v);
    logic signed [MAC_ODATA_BIT-1:0] s;
    s = v;
    return ACC_BIT'(s);
  endfunction

  assign cfg_ready       = (state_q == S_IDLE);
  assign in_ready        = (state_q == S_ISSUE);
  assign out_valid       = (state_q == S_DONE);
  assign busy            = (state_q != S_IDLE);
  assign err_spurious    = err_spurious_q;
  assign out_data        = out_data_q;

  assign cfg_fire        = cfg_valid & cfg_ready;
  assign in_fire         = in_valid & in_ready;
  assign out_fire        = out_valid & out_ready;

  // Operands pass straight through; core_mac has no backpressure so a beat is a MAC issue.
  assign mac_idataA      = in_dataA;
  assign mac_idataB      = in_dataB;
  assign mac_idata_valid = in_fire;

  // Returns are only meaningful while a job is outstanding; anything else is stray.
  assign ret_live  = mac_odata_valid & ((state_q == S_ISSUE) | (state_q == S_DRAIN));
  assign ret_stray = mac_odata_valid & ((state_q == S_IDLE)  | (state_q == S_DONE));

  // Next-state, accumulation and counter update logic.
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    out_data_d     = out_data_q;
    issue_cnt_d    = issue_cnt_q;
    ret_cnt_d      = ret_cnt_q;
    chunk_num_d    = chunk_num_q;
    err_spurious_d = err_spurious_q | ret_stray;

    if (ret_live) begin
      acc_d     = acc_q + sext_ret(mac_odata);
      ret_cnt_d = ret_cnt_q + CNT_BIT'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (cfg_fire) begin
          chunk_num_d    = cfg_chunk_num;
          acc_d          = '0;
          issue_cnt_d    = '0;
          ret_cnt_d      = '0;
          // A stray return landing on the accept cycle still gets flagged.
          err_spurious_d = ret_stray;
          if (cfg_chunk_num == '0) begin
            state_d    = S_DONE;
            out_data_d = '0;
          end else begin
            state_d    = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (in_fire) begin
          issue_cnt_d = issue_cnt_q + CNT_BIT'(1);
          if (issue_cnt_q == chunk_num_q - CNT_BIT'(1)) begin
            // A zero-latency MAC could already have returned everything.
            if (ret_cnt_d == chunk_num_q) begin
              state_d    = S_DONE;
              out_data_d = acc_d;
            end else begin
              state_d    = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        if (ret_live && (ret_cnt_d == chunk_num_q)) begin
          state_d    = S_DONE;
          out_data_d = acc_d;
        end
      end
      S_DONE: begin
        if (out_fire) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any job in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= S_IDLE;
      acc_q          <= '0;
      out_data_q     <= '0;
      issue_cnt_q    <= '0;
      ret_cnt_q      <= '0;
      chunk_num_q    <= '0;
      err_spurious_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      out_data_q     <= out_data_d;
      issue_cnt_q    <= issue_cnt_d;
      ret_cnt_q      <= ret_cnt_d;
      chunk_num_q    <= chunk_num_d;
      err_spurious_q <= err_spurious_d;
    end
  end

endmodule

// File: tb/tb_core_mac_seq.sv
// Testbench for core_mac_seq: a fixed-latency core_mac stand-in drives returns,
// jobs come from a vector table plus random jobs, and results are compared to a
// plain-arithmetic dot product. A second instance with ACC_BIT=20 shares stimulus.
module tb_core_mac_seq;
  localparam int MAC_NUM = 8;
  localparam int DW      = 8 * MAC_NUM;
  localparam int LAT     = 3;

  logic          clk  = 1'b0;
  logic          rstn = 1'b0;
  always #5 clk = ~clk;

  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [7:0]    cfg_chunk_num = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_dataA = '0;
  logic [DW-1:0] in_dataB = '0;
  logic [DW-1:0] mac_idataA, mac_idataB;
  logic          mac_idata_valid;
  logic [18:0]   mac_odata;
  logic          mac_odata_valid;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_data;
  logic          busy, err_spurious;

  logic          cfg_ready20, in_ready20, mac_idata_valid20, out_valid20, busy20, err20;
  logic [DW-1:0] mac_idataA20, mac_idataB20;
  logic [19:0]   out_data20;

  core_mac_seq #(.MAC_NUM(8), .IDATA_BIT(8), .MAC_ODATA_BIT(19), .ACC_BIT(32), .CNT_BIT(8)) u_dut (
    .clk(clk), .rstn(rstn),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chunk_num(cfg_chunk_num),
    .in_valid(in_valid), .in_ready(in_ready), .in_dataA(in_dataA), .in_dataB(in_dataB),
    .mac_idataA(mac_idataA), .mac_idataB(mac_idataB), .mac_idata_valid(mac_idata_valid),
    .mac_odata(mac_odata), .mac_odata_valid(mac_odata_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .err_spurious(err_spurious)
  );

  core_mac_seq #(.MAC_NUM(8), .IDATA_BIT(8), .MAC_ODATA_BIT(19), .ACC_BIT(20), .CNT_BIT(8)) u_dut20 (
    .clk(clk), .rstn(rstn),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready20), .cfg_chunk_num(cfg_chunk_num),
    .in_valid(in_valid), .in_ready(in_ready20), .in_dataA(in_dataA), .in_dataB(in_dataB),
    .mac_idataA(mac_idataA20), .mac_idataB(mac_idataB20), .mac_idata_valid(mac_idata_valid20),
    .mac_odata(mac_odata), .mac_odata_valid(mac_odata_valid),
    .out_valid(out_valid20), .out_ready(out_ready), .out_data(out_data20),
    .busy(busy20), .err_spurious(err20)
  );

  // core_mac stand-in: fixed latency, reset together with the sequencer.
  logic [LAT-1:0]     pv;
  logic signed [18:0] pd [LAT];
  logic               inj_v = 1'b0;
  logic [18:0]        inj_d = '0;

  function automatic logic signed [18:0] lane_dot(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int s;
    s = 0;
    for (int i = 0; i < MAC_NUM; i++)
      s += int'($signed(a[i*8+:8])) * int'($signed(b[i*8+:8]));
    return 19'(s);
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pv <= '0;
      for (int i = 0; i < LAT; i++) pd[i] <= '0;
    end else begin
      pv    <= {pv[LAT-2:0], mac_idata_valid};
      pd[0] <= lane_dot(mac_idataA, mac_idataB);
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end
  end

  assign mac_odata_valid = pv[LAT-1] | inj_v;
  assign mac_odata       = inj_v ? inj_d : pd[LAT-1];

  int n_iss = 0;
  int n_ret = 0;
  always @(posedge clk) begin
    if (mac_idata_valid) n_iss++;
    if (pv[LAT-1])       n_ret++;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          n;
    bit          rnd;
    logic [7:0]  a;
    logic [7:0]  b;
    int          gap;
    int          hold;
    bit          spur;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t tbl [6];

  task automatic run_job(input vec_t v);
    longint        ref_sum;
    logic [31:0]   exp32;
    logic [31:0]   held;
    logic [DW-1:0] a, b;
    int            issued, cyc, iss0, ret0;
    bit            beat;
    ref_sum = 0;
    issued  = 0;
    cyc     = 0;
    @(negedge clk);
    chk({v.nm, " cfg_ready idle"}, 64'(cfg_ready), 64'd1);
    cfg_valid     = 1'b1;
    cfg_chunk_num = 8'(v.n);
    iss0 = n_iss;
    ret0 = n_ret;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk({v.nm, " err cleared by accept"}, 64'(err_spurious), 64'd0);
    if (v.n == 0) chk({v.nm, " out_valid cycle after accept"}, 64'(out_valid), 64'd1);
    while (issued < v.n && cyc < 5000) begin
      beat = in_ready && (int'($urandom_range(99)) >= v.gap);
      for (int i = 0; i < MAC_NUM; i++) begin
        a[i*8+:8] = v.rnd ? 8'($urandom) : v.a;
        b[i*8+:8] = v.rnd ? 8'($urandom) : v.b;
      end
      in_dataA = a;
      in_dataB = b;
      in_valid = beat;
      if (beat)
        for (int i = 0; i < MAC_NUM; i++)
          ref_sum += longint'($signed(a[i*8+:8])) * longint'($signed(b[i*8+:8]));
      @(negedge clk);
      cyc++;
      if (beat) issued++;
    end
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk({v.nm, " out_valid reached"}, 64'(out_valid), 64'd1);
    exp32 = v.rnd ? 32'(ref_sum) : v.exp;
    chk({v.nm, " out_data"}, 64'(out_data), 64'(exp32));
    chk({v.nm, " out_data acc20"}, 64'(out_data20), 64'(exp32[19:0]));
    chk({v.nm, " out_valid acc20"}, 64'(out_valid20), 64'd1);
    chk({v.nm, " issues"}, 64'(n_iss - iss0), 64'(v.n));
    chk({v.nm, " returns"}, 64'(n_ret - ret0), 64'(v.n));
    chk({v.nm, " err clean"}, 64'(err_spurious), 64'd0);
    chk({v.nm, " busy in done"}, 64'(busy), 64'd1);
    held = out_data;
    for (int h = 0; h < v.hold; h++) begin
      if (v.spur && h == 1) begin
        inj_v = 1'b1;
        inj_d = 19'h00123;
      end
      @(negedge clk);
      inj_v = 1'b0;
      chk({v.nm, " hold out_valid"}, 64'(out_valid), 64'd1);
      chk({v.nm, " hold out_data"}, 64'(out_data), 64'(held));
      chk({v.nm, " hold cfg_ready"}, 64'(cfg_ready), 64'd0);
    end
    if (v.spur) chk({v.nm, " err set by return in done"}, 64'(err_spurious), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({v.nm, " out_valid after handshake"}, 64'(out_valid), 64'd0);
    chk({v.nm, " busy after handshake"}, 64'(busy), 64'd0);
    chk({v.nm, " out_data kept in idle"}, 64'(out_data), 64'(exp32));
  endtask

  initial begin
    vec_t r;
    tbl[0] = '{1,   1'b0, 8'h01, 8'h02, 0,  0, 1'b0, 32'd16,        "T1"};
    tbl[1] = '{4,   1'b0, 8'hFF, 8'h03, 0,  0, 1'b0, 32'hFFFFFFA0,  "T2"};
    tbl[2] = '{4,   1'b0, 8'hFF, 8'h03, 40, 5, 1'b1, 32'hFFFFFFA0,  "T3"};
    tbl[3] = '{0,   1'b0, 8'h00, 8'h00, 0,  0, 1'b0, 32'd0,         "T4"};
    tbl[4] = '{4,   1'b0, 8'h80, 8'h80, 0,  1, 1'b0, 32'h00080000,  "T6"};
    tbl[5] = '{255, 1'b1, 8'h00, 8'h00, 0,  1, 1'b0, 32'd0,         "MAXCHUNK"};

    repeat (3) @(negedge clk);
    chk("reset cfg_ready", 64'(cfg_ready), 64'd1);
    chk("reset in_ready", 64'(in_ready), 64'd0);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_data", 64'(out_data), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset err", 64'(err_spurious), 64'd0);
    chk("reset mac_idata_valid", 64'(mac_idata_valid), 64'd0);
    rstn = 1'b1;

    for (int k = 0; k < 6; k++) run_job(tbl[k]);

    for (int k = 0; k < 6; k++) begin
      r.n    = int'($urandom_range(1, 12));
      r.rnd  = 1'b1;
      r.a    = '0;
      r.b    = '0;
      r.gap  = 30;
      r.hold = int'($urandom_range(0, 3));
      r.spur = 1'b0;
      r.exp  = '0;
      r.nm   = "RND";
      run_job(r);
    end

    // Reset in the middle of ISSUE after two of four chunks.
    @(negedge clk);
    cfg_valid     = 1'b1;
    cfg_chunk_num = 8'd4;
    @(negedge clk);
    cfg_valid = 1'b0;
    in_dataA  = {8{8'hFF}};
    in_dataB  = {8{8'h03}};
    in_valid  = 1'b1;
    repeat (2) @(negedge clk);
    chk("T5 in_ready mid issue", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    rstn     = 1'b0;
    #1;
    chk("T5 reset busy", 64'(busy), 64'd0);
    chk("T5 reset cfg_ready", 64'(cfg_ready), 64'd1);
    chk("T5 reset in_ready", 64'(in_ready), 64'd0);
    chk("T5 reset out_valid", 64'(out_valid), 64'd0);
    chk("T5 reset out_data", 64'(out_data), 64'd0);
    chk("T5 reset out_data acc20", 64'(out_data20), 64'd0);
    chk("T5 reset err", 64'(err_spurious), 64'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    run_job(tbl[1]);

    // Stray return while idle: flagged, result untouched, cleared by next accept.
    @(negedge clk);
    inj_v = 1'b1;
    inj_d = 19'h00007;
    @(negedge clk);
    inj_v = 1'b0;
    chk("IDLE stray err set", 64'(err_spurious), 64'd1);
    chk("IDLE stray out_data kept", 64'(out_data), 64'hFFFFFFA0);
    run_job(tbl[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
